// File: rtl/decode_pkg.sv
// decode_pkg: shared encodings, field positions and helpers for the decode stage
package decode_pkg;
   localparam logic [31:0] NOP      = 32'h0;
   localparam logic [5:0]  OP_RTYPE = 6'h00;
   localparam logic [5:0]  OP_J     = 6'h02;
   localparam logic [5:0]  OP_BEQ   = 6'h04;
   localparam logic [5:0]  OP_BNE   = 6'h05;
   localparam logic [5:0]  OP_ADDI  = 6'h08;
   localparam logic [5:0]  OP_LW    = 6'h23;
   localparam logic [5:0]  OP_SW    = 6'h2b;
   localparam logic [5:0]  FN_ADD   = 6'h20;
   localparam logic [5:0]  FN_SUB   = 6'h22;
   localparam logic [5:0]  FN_AND   = 6'h24;
   localparam logic [5:0]  FN_OR    = 6'h25;
   localparam logic [5:0]  FN_SLT   = 6'h2a;
   localparam int          REG_AW   = 5;
   localparam int          RS_LSB   = 21;
   localparam int          RT_LSB   = 16;
   localparam int          RD_LSB   = 11;
   localparam int          IMM_W    = 16;

   function automatic logic [31:0] sign_ext(input logic [IMM_W-1:0] imm);
      return {{(32-IMM_W){imm[IMM_W-1]}}, imm};
   endfunction
endpackage

// File: rtl/decode_if.sv
// decode_if: bus between the decode stage and its neighbours (fetch, hazard unit, execute, writeback)
interface decode_if;
   import decode_pkg::*;
   logic [31:0]       instructionf;
   logic [31:0]       pc_plus_4f;
   logic              stall_d;
   logic              branch_d;
   logic              branch_ne_d;
   logic              forward_a_d;
   logic              forward_b_d;
   logic [31:0]       alu_out_m;
   logic              reg_write_w;
   logic [REG_AW-1:0] write_reg_w;
   logic [31:0]       result_w;
   logic [31:0]       instr_d;
   logic [31:0]       rd1_d;
   logic [31:0]       rd2_d;
   logic [31:0]       sign_imm_d;
   logic [REG_AW-1:0] rs_d;
   logic [REG_AW-1:0] rt_d;
   logic [REG_AW-1:0] rd_d;
   logic [31:0]       pc_branch_d;
   logic              pcsrc_d;

   modport master (
      output instructionf, pc_plus_4f, stall_d, branch_d, branch_ne_d, forward_a_d,
             forward_b_d, alu_out_m, reg_write_w, write_reg_w, result_w,
      input  instr_d, rd1_d, rd2_d, sign_imm_d, rs_d, rt_d, rd_d, pc_branch_d, pcsrc_d
   );
   modport slave (
      input  instructionf, pc_plus_4f, stall_d, branch_d, branch_ne_d, forward_a_d,
             forward_b_d, alu_out_m, reg_write_w, write_reg_w, result_w,
      output instr_d, rd1_d, rd2_d, sign_imm_d, rs_d, rt_d, rd_d, pc_branch_d, pcsrc_d
   );
endinterface

// File: rtl/decode_regfile.sv
// regfile: 2-read/1-write register file with write-through bypass and hardwired zero register
module regfile
   import decode_pkg::*;
#(
   parameter int REG_COUNT = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] ra1_i,
   input  logic [REG_AW-1:0] ra2_i,
   input  logic              we_i,
   input  logic [REG_AW-1:0] wa_i,
   input  logic [31:0]       wd_i,
   output logic [31:0]       rd1_o,
   output logic [31:0]       rd2_o
);
   logic [31:0] regs_q [REG_COUNT];
   logic        wr_en;

   assign wr_en = we_i && wa_i != '0;

   // storage: cleared on reset, writes to register 0 dropped
   always_ff @(posedge clk or posedge reset) begin
      if (reset) for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
      else if (wr_en) regs_q[wa_i] <= wd_i;
   end

   // reads: zero register first, then same-cycle writeback bypass, then storage
   always_comb begin
      rd1_o = ra1_i == '0 ? '0 : (wr_en && ra1_i == wa_i) ? wd_i : regs_q[ra1_i];
      rd2_o = ra2_i == '0 ? '0 : (wr_en && ra2_i == wa_i) ? wd_i : regs_q[ra2_i];
   end
endmodule

// File: rtl/decode.sv
// decode: IF/ID register, register file, sign extension and early branch resolution
module decode
   import decode_pkg::*;
#(
   parameter int REG_COUNT = 32
) (
   input logic    clk,
   input logic    reset,
   decode_if.slave bus
);
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic [31:0] ifid_pc4_q, ifid_pc4_d;
   logic [31:0] rd1, rd2, sign_imm, src_a, src_b, target;
   logic        eq, pcsrc;

   // IF/ID next state: stall holds (and beats flush), taken branch squashes, else load
   always_comb begin
      ifid_instr_d = bus.stall_d ? ifid_instr_q : pcsrc ? NOP : bus.instructionf;
      ifid_pc4_d   = bus.stall_d ? ifid_pc4_q : pcsrc ? '0 : bus.pc_plus_4f;
   end

   // IF/ID register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ifid_instr_q <= NOP;
         ifid_pc4_q   <= '0;
      end else begin
         ifid_instr_q <= ifid_instr_d;
         ifid_pc4_q   <= ifid_pc4_d;
      end
   end

   regfile #(.REG_COUNT(REG_COUNT)) u_rf (
      .clk   (clk),
      .reset (reset),
      .ra1_i (ifid_instr_q[RS_LSB +: REG_AW]),
      .ra2_i (ifid_instr_q[RT_LSB +: REG_AW]),
      .we_i  (bus.reg_write_w),
      .wa_i  (bus.write_reg_w),
      .wd_i  (bus.result_w),
      .rd1_o (rd1),
      .rd2_o (rd2)
   );

   // branch compare on forwarded operands and wrap-around target add
   always_comb begin
      sign_imm = sign_ext(ifid_instr_q[IMM_W-1:0]);
      src_a    = bus.forward_a_d ? bus.alu_out_m : rd1;
      src_b    = bus.forward_b_d ? bus.alu_out_m : rd2;
      eq       = src_a == src_b;
      pcsrc    = (bus.branch_d & eq) | (bus.branch_ne_d & ~eq);
      target   = ifid_pc4_q + (sign_imm << 2);
   end

   assign bus.instr_d     = ifid_instr_q;
   assign bus.rd1_d       = rd1;
   assign bus.rd2_d       = rd2;
   assign bus.sign_imm_d  = sign_imm;
   assign bus.rs_d        = ifid_instr_q[RS_LSB +: REG_AW];
   assign bus.rt_d        = ifid_instr_q[RT_LSB +: REG_AW];
   assign bus.rd_d        = ifid_instr_q[RD_LSB +: REG_AW];
   assign bus.pc_branch_d = target;
   assign bus.pcsrc_d     = pcsrc;
endmodule

// File: tb/tb_decode.sv
// tb_decode: self-checking bench for the decode stage
module tb_decode;
   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail = 0;

   decode_if bus ();
   decode dut (.clk(clk), .reset(reset), .bus(bus.slave));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        fa;
      logic        fb;
      logic [31:0] alu;
      logic        beq;
      logic        bne;
      logic        exp_pcsrc;
      logic [31:0] exp_target;
   } vec_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] simm;
      logic [31:0] target;
      logic        pcsrc;
   } exp_t;

   vec_t vecs [11];
   exp_t sb [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic ctl_idle();
      bus.branch_d    = 1'b0;
      bus.branch_ne_d = 1'b0;
      bus.forward_a_d = 1'b0;
      bus.forward_b_d = 1'b0;
      bus.stall_d     = 1'b0;
      bus.alu_out_m   = '0;
   endtask

   task automatic wb(input logic [4:0] r, input logic [31:0] v);
      bus.reg_write_w = 1'b1;
      bus.write_reg_w = r;
      bus.result_w    = v;
      @(posedge clk);
      #1;
      bus.reg_write_w = 1'b0;
   endtask

   initial begin
      exp_t e;
      vecs = '{
         '{32'h1022FFFF, 32'h00000010, 0, 0, 32'h0, 1, 0, 1, 32'h0000000C},
         '{32'h10230002, 32'h00000100, 0, 0, 32'h0, 1, 0, 0, 32'h00000108},
         '{32'h14230002, 32'h00000100, 0, 0, 32'h0, 0, 1, 1, 32'h00000108},
         '{32'h14030000, 32'h00000020, 1, 0, 32'h7, 0, 1, 0, 32'h00000020},
         '{32'h14030000, 32'h00000020, 1, 0, 32'h8, 0, 1, 1, 32'h00000020},
         '{32'h10800010, 32'h00000040, 0, 1, 32'h9, 1, 0, 1, 32'h00000080},
         '{32'h10230002, 32'h00000100, 0, 0, 32'h0, 1, 1, 1, 32'h00000108},
         '{32'h10220002, 32'h00000100, 0, 0, 32'h0, 1, 1, 1, 32'h00000108},
         '{32'h10000001, 32'hFFFFFFFC, 0, 0, 32'h0, 0, 0, 0, 32'h00000000},
         '{32'h10008000, 32'h00010000, 0, 0, 32'h0, 0, 0, 0, 32'hFFFF0000},
         '{32'h10220000, 32'h00000000, 0, 0, 32'h0, 0, 1, 0, 32'h00000000}
      };
      ctl_idle();
      bus.reg_write_w  = 1'b0;
      bus.write_reg_w  = '0;
      bus.result_w     = '0;
      reset            = 1'b1;
      bus.instructionf = 32'h8C080004;
      bus.pc_plus_4f   = 32'h4;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("reset instr_d", bus.instr_d, 32'h0);
      chk("reset rd1", bus.rd1_d, 32'h0);
      chk("reset rd2", bus.rd2_d, 32'h0);
      chk("reset pcsrc", {31'h0, bus.pcsrc_d}, 32'h0);
      #1 reset = 1'b0;
      @(posedge clk);
      #1;
      chk("load instr_d", bus.instr_d, 32'h8C080004);
      chk("load rt_d", {27'h0, bus.rt_d}, 32'd8);
      chk("load rs_d", {27'h0, bus.rs_d}, 32'd0);
      chk("load sign_imm", bus.sign_imm_d, 32'h4);
      chk("load pc_branch", bus.pc_branch_d, 32'h14);
      bus.instructionf = 32'h01200000;
      @(posedge clk);
      #1;
      bus.reg_write_w = 1'b1;
      bus.write_reg_w = 5'd9;
      bus.result_w    = 32'hDEADBEEF;
      #1;
      chk("bypass rd1", bus.rd1_d, 32'hDEADBEEF);
      @(posedge clk);
      #1;
      bus.reg_write_w = 1'b0;
      bus.result_w    = 32'h0;
      #1;
      chk("stored r9", bus.rd1_d, 32'hDEADBEEF);
      bus.instructionf = 32'h0;
      @(posedge clk);
      #1;
      bus.reg_write_w = 1'b1;
      bus.write_reg_w = 5'd0;
      bus.result_w    = 32'h12345678;
      #1;
      chk("r0 no bypass rd1", bus.rd1_d, 32'h0);
      chk("r0 no bypass rd2", bus.rd2_d, 32'h0);
      @(posedge clk);
      #1;
      bus.reg_write_w = 1'b0;
      #1;
      chk("r0 after write", bus.rd1_d, 32'h0);
      wb(5'd1, 32'd5);
      wb(5'd2, 32'd5);
      wb(5'd3, 32'd7);
      wb(5'd4, 32'd9);
      foreach (vecs[i]) begin
         bus.instructionf = vecs[i].instr;
         bus.pc_plus_4f   = vecs[i].pc4;
         @(posedge clk);
         #1;
         bus.forward_a_d = vecs[i].fa;
         bus.forward_b_d = vecs[i].fb;
         bus.alu_out_m   = vecs[i].alu;
         bus.branch_d    = vecs[i].beq;
         bus.branch_ne_d = vecs[i].bne;
         sb.push_back('{vecs[i].instr, {{16{vecs[i].instr[15]}}, vecs[i].instr[15:0]},
                        vecs[i].exp_target, vecs[i].exp_pcsrc});
         @(negedge clk);
         e = sb.pop_front();
         chk($sformatf("vec%0d instr_d", i), bus.instr_d, e.instr);
         chk($sformatf("vec%0d sign_imm", i), bus.sign_imm_d, e.simm);
         chk($sformatf("vec%0d pc_branch", i), bus.pc_branch_d, e.target);
         chk($sformatf("vec%0d pcsrc", i), {31'h0, bus.pcsrc_d}, {31'h0, e.pcsrc});
         ctl_idle();
      end
      bus.instructionf = 32'h1022FFFF;
      bus.pc_plus_4f   = 32'h10;
      @(posedge clk);
      #1;
      bus.branch_d     = 1'b1;
      bus.instructionf = 32'hAAAA5555;
      bus.pc_plus_4f   = 32'h50;
      #1;
      chk("taken pcsrc", {31'h0, bus.pcsrc_d}, 32'h1);
      chk("taken target", bus.pc_branch_d, 32'hC);
      @(posedge clk);
      #1;
      chk("flush instr_d", bus.instr_d, 32'h0);
      chk("flush pc_branch", bus.pc_branch_d, 32'h0);
      ctl_idle();
      bus.instructionf = 32'h1022FFFF;
      bus.pc_plus_4f   = 32'h10;
      @(posedge clk);
      #1;
      bus.branch_d     = 1'b1;
      bus.stall_d      = 1'b1;
      bus.instructionf = 32'hAAAA5555;
      bus.pc_plus_4f   = 32'h50;
      @(posedge clk);
      #1;
      chk("stall instr_d", bus.instr_d, 32'h1022FFFF);
      chk("stall pc_branch", bus.pc_branch_d, 32'hC);
      chk("stall pcsrc", {31'h0, bus.pcsrc_d}, 32'h1);
      ctl_idle();
      bus.instructionf = 32'h01200000;
      bus.pc_plus_4f   = 32'h80;
      @(posedge clk);
      #1;
      chk("pre-reset r9", bus.rd1_d, 32'hDEADBEEF);
      reset = 1'b1;
      #1;
      chk("midreset instr_d", bus.instr_d, 32'h0);
      chk("midreset sign_imm", bus.sign_imm_d, 32'h0);
      chk("midreset pc_branch", bus.pc_branch_d, 32'h0);
      chk("midreset pcsrc", {31'h0, bus.pcsrc_d}, 32'h0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1;
      chk("post-reset instr_d", bus.instr_d, 32'h01200000);
      chk("post-reset r9", bus.rd1_d, 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
